fft_layer_writeback: RTL

//   Write-side counterpart of the per-layer FFT read address generator.
//   - Accepts butterfly result pairs (A,B) from the FFT pipe.
//   - Generates the matching write addresses, data and write enable for the destination

---
 rtl/fft_layer_writeback_pkg.sv | 32 +++
 rtl/fft_layer_writeback_part_counter.sv | 53 +++++
 rtl/fft_layer_writeback.sv | 118 +++++++++++
 3 files changed

// File: rtl/fft_layer_writeback_pkg.sv
// Shared FFT layer definitions: writeback FSM state encoding and per-layer partition geometry.
// The read-side address generator uses the same helpers so both sides agree on the layout.
package fft_layer_writeback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_t;

    function automatic int layer_order(input int fft_size, input int layer_num);
        return $clog2(fft_size) - 1 - layer_num;
    endfunction

    function automatic int num_parts(input int fft_size, input int layer_num);
        return 1 << layer_order(fft_size, layer_num);
    endfunction

    function automatic int part_len(input int fft_size, input int layer_num);
        return fft_size / num_parts(fft_size, layer_num);
    endfunction

    function automatic int part_mid(input int fft_size, input int layer_num);
        return part_len(fft_size, layer_num) / 2;
    endfunction

    // A counter with a single legal value still needs one bit.
    function automatic int cnt_w(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/fft_layer_writeback_part_counter.sv
// Nested position/partition counter for one FFT layer; exposes the pair index in effect
// this cycle (already cleared when clr is high) and a flag marking the last pair.
module fft_part_counter
    import fft_layer_writeback_pkg::*;
#(
    parameter int PART_MID  = 1,
    parameter int NUM_PARTS = 4,
    parameter int POS_W     = cnt_w(PART_MID),
    parameter int PART_W    = cnt_w(NUM_PARTS)
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              clr,
    input  logic              inc,
    output logic [POS_W-1:0]  pos,
    output logic [PART_W-1:0] part,
    output logic              last
);

    localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(PART_MID - 1);
    localparam logic [PART_W-1:0] PART_MAX = PART_W'(NUM_PARTS - 1);

    logic [POS_W-1:0]  pos_q;
    logic [PART_W-1:0] part_q;

    // A clear and an increment in the same cycle count the current pair as pair 0.
    always_comb begin
        pos  = clr ? '0 : pos_q;
        part = clr ? '0 : part_q;
        last = (pos == POS_MAX) && (part == PART_MAX);
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            pos_q  <= '0;
            part_q <= '0;
        end else begin
            if (clr) begin
                pos_q  <= '0;
                part_q <= '0;
            end
            if (inc && !last) begin
                if (pos == POS_MAX) begin
                    pos_q  <= '0;
                    part_q <= part + PART_W'(1);
                end else begin
                    pos_q  <= pos + POS_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fft_layer_writeback.sv
// Per-layer FFT writeback: turns butterfly result pairs into registered dual-port writes
// to the destination bank and flags completion of the layer.
module fft_layer_writeback
    import fft_layer_writeback_pkg::*;
#(
    parameter int FFT_SIZE  = 8,
    parameter int LAYER_NUM = 0,
    parameter int ADDR_SIZE = 5,
    parameter int DATA_W    = 32
) (
    input  logic                 i_CLK,
    input  logic                 i_RST_N,
    input  logic                 i_start,
    input  logic                 i_valid,
    input  logic [DATA_W-1:0]    i_data_A,
    input  logic [DATA_W-1:0]    i_data_B,
    output logic                 o_wren,
    output logic [ADDR_SIZE-1:0] o_wraddr_A,
    output logic [ADDR_SIZE-1:0] o_wraddr_B,
    output logic [DATA_W-1:0]    o_wrdata_A,
    output logic [DATA_W-1:0]    o_wrdata_B,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int NUM_PARTS = num_parts(FFT_SIZE, LAYER_NUM);
    localparam int PART_LEN  = part_len(FFT_SIZE, LAYER_NUM);
    localparam int PART_MID  = part_mid(FFT_SIZE, LAYER_NUM);
    localparam int POS_W     = cnt_w(PART_MID);
    localparam int PART_W    = cnt_w(NUM_PARTS);

    localparam logic [ADDR_SIZE-1:0] PART_LEN_A = ADDR_SIZE'(PART_LEN);
    localparam logic [ADDR_SIZE-1:0] PART_MID_A = ADDR_SIZE'(PART_MID);

    wb_state_t             state_q;
    wb_state_t             state_nxt;
    logic                  vld_p0;
    logic [POS_W-1:0]      pos_p0;
    logic [PART_W-1:0]     part_p0;
    logic                  last_p0;
    logic [ADDR_SIZE-1:0]  addr_a_p0;
    logic [ADDR_SIZE-1:0]  addr_b_p0;

    logic                  vld_p1;
    logic [ADDR_SIZE-1:0]  addr_a_p1;
    logic [ADDR_SIZE-1:0]  addr_b_p1;
    logic [DATA_W-1:0]     data_a_p1;
    logic [DATA_W-1:0]     data_b_p1;
    logic                  busy_p1;
    logic                  done_p1;
    logic                  err_p1;

    fft_part_counter #(
        .PART_MID  (PART_MID),
        .NUM_PARTS (NUM_PARTS),
        .POS_W     (POS_W),
        .PART_W    (PART_W)
    ) u_cnt (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .clr     (i_start),
        .inc     (vld_p0),
        .pos     (pos_p0),
        .part    (part_p0),
        .last    (last_p0)
    );

    // p0: accept decision, next state and write addresses for the pair on the inputs
    always_comb begin
        vld_p0    = i_valid && (i_start || (state_q == ST_RUN));
        state_nxt = state_q;
        if (i_start) begin
            state_nxt = (vld_p0 && last_p0) ? ST_DONE : ST_RUN;
        end else if ((state_q == ST_RUN) && vld_p0 && last_p0) begin
            state_nxt = ST_DONE;
        end
        addr_a_p0 = ADDR_SIZE'(part_p0) * PART_LEN_A + ADDR_SIZE'(pos_p0);
        addr_b_p0 = addr_a_p0 + PART_MID_A;
    end

    // p1: registered write port and status flags
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q   <= ST_IDLE;
            vld_p1    <= 1'b0;
            addr_a_p1 <= '0;
            addr_b_p1 <= '0;
            data_a_p1 <= '0;
            data_b_p1 <= '0;
            busy_p1   <= 1'b0;
            done_p1   <= 1'b0;
            err_p1    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            vld_p1  <= vld_p0;
            if (vld_p0) begin
                addr_a_p1 <= addr_a_p0;
                addr_b_p1 <= addr_b_p0;
                data_a_p1 <= i_data_A;
                data_b_p1 <= i_data_B;
            end
            busy_p1 <= (state_nxt == ST_RUN);
            done_p1 <= (state_nxt == ST_DONE);
            err_p1  <= i_valid && !vld_p0;
        end
    end

    assign o_wren     = vld_p1;
    assign o_wraddr_A = addr_a_p1;
    assign o_wraddr_B = addr_b_p1;
    assign o_wrdata_A = data_a_p1;
    assign o_wrdata_B = data_b_p1;
    assign o_busy     = busy_p1;
    assign o_done     = done_p1;
    assign o_err      = err_p1;

endmodule
